// File: rtl/out_port_sched.sv
// Output-port packet scheduler: picks one whole packet by header priority
// (round-robin on ties), pops it word by word and drives the port registers.
module out_port_sched #(
  parameter int N_SRC = 3,
  parameter int DW    = 8,
  parameter int PRI_W = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_SRC-1:0]    src_vld,
  input  logic [N_SRC-1:0]    src_sop,
  input  logic [N_SRC-1:0]    src_eop,
  input  logic [N_SRC*DW-1:0] src_data,
  output logic [N_SRC-1:0]    src_rd_en,
  input  logic                out_ready,
  output logic                rd_sop,
  output logic                rd_eop,
  output logic                rd_vld,
  output logic [DW-1:0]       rd_data,
  output logic [N_SRC-1:0]    gnt,
  output logic                busy,
  output logic [15:0]         pkt_cnt
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [N_SRC-1:0] gnt_r, gnt_nxt_s;
  logic [IW-1:0]    g_idx_r, g_idx_nxt_s;
  logic [IW-1:0]    last_r, last_nxt_s;
  logic [15:0]      pkt_cnt_r, pkt_cnt_nxt_s;
  logic             busy_r;
  logic             rd_sop_r, rd_eop_r, rd_vld_r;
  logic [DW-1:0]    rd_data_r;

  logic [N_SRC-1:0] req_s;
  logic [N_SRC-1:0] src_rd_en_s;
  logic             win_found_s;
  logic [IW-1:0]    win_idx_s;
  logic [PRI_W-1:0] best_pri_s;
  int               idx_v;
  logic             pop_s;
  logic             head_sop_s, head_eop_s;
  logic [DW-1:0]    head_data_s;

  assign req_s = src_vld & src_sop;

  // Arbiter: scan last+1, last+2, ... and keep only a strictly higher priority,
  // so the first requester in round-robin order wins among equals.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    best_pri_s  = {PRI_W{1'b0}};
    idx_v       = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx_v = (int'(last_r) + k) % N_SRC;
      if (req_s[idx_v] && (!win_found_s || (src_data[idx_v*DW+4 +: PRI_W] > best_pri_s))) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'(idx_v);
        best_pri_s  = src_data[idx_v*DW+4 +: PRI_W];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Pop strobe for the granted queue
  always_comb begin
    src_rd_en_s = {N_SRC{1'b0}};
    if (state_r == XFER) begin
      src_rd_en_s = gnt_r & src_vld & {N_SRC{out_ready}};
    end else begin
      src_rd_en_s = {N_SRC{1'b0}};
    end
  end

  assign pop_s       = |src_rd_en_s;
  assign head_sop_s  = src_sop[g_idx_r];
  assign head_eop_s  = src_eop[g_idx_r];
  assign head_data_s = src_data[int'(g_idx_r)*DW +: DW];

  // Next-state logic: grant in IDLE, release after the eop word is popped
  always_comb begin
    state_nxt_s   = state_r;
    gnt_nxt_s     = gnt_r;
    g_idx_nxt_s   = g_idx_r;
    last_nxt_s    = last_r;
    pkt_cnt_nxt_s = pkt_cnt_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = XFER;
          gnt_nxt_s   = {{(N_SRC-1){1'b0}}, 1'b1} << win_idx_s;
          g_idx_nxt_s = win_idx_s;
        end else begin
          gnt_nxt_s = {N_SRC{1'b0}};
        end
      end
      XFER: begin
        if (pop_s && head_eop_s) begin
          state_nxt_s   = IDLE;
          gnt_nxt_s     = {N_SRC{1'b0}};
          last_nxt_s    = g_idx_r;
          pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = {N_SRC{1'b0}};
      end
    endcase
  end

  // State, grant and output registers
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r   <= IDLE;
      gnt_r     <= {N_SRC{1'b0}};
      g_idx_r   <= {IW{1'b0}};
      last_r    <= IW'(N_SRC - 1);
      pkt_cnt_r <= 16'd0;
      busy_r    <= 1'b0;
      rd_vld_r  <= 1'b0;
      rd_sop_r  <= 1'b0;
      rd_eop_r  <= 1'b0;
      rd_data_r <= {DW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      gnt_r     <= gnt_nxt_s;
      g_idx_r   <= g_idx_nxt_s;
      last_r    <= last_nxt_s;
      pkt_cnt_r <= pkt_cnt_nxt_s;
      busy_r    <= (state_nxt_s == XFER);
      rd_vld_r  <= pop_s;
      if (pop_s) begin
        rd_sop_r  <= head_sop_s;
        rd_eop_r  <= head_eop_s;
        rd_data_r <= head_data_s;
      end else begin
        rd_sop_r  <= 1'b0;
        rd_eop_r  <= 1'b0;
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign src_rd_en = src_rd_en_s;
  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign pkt_cnt   = pkt_cnt_r;
  assign rd_vld    = rd_vld_r;
  assign rd_sop    = rd_sop_r;
  assign rd_eop    = rd_eop_r;
  assign rd_data   = rd_data_r;

endmodule

// File: doc/out_port_sched.md
# out_port_sched

Per-output-port packet scheduler for the 3-port switch. Sits between the per-source packet queues holding traffic for one destination port and that port's read interface (`rd_sop/eop/vld/data`). It chooses one whole packet at a time by strict header priority, with round-robin among equal priorities. It pops the chosen queue word by word under downstream backpressure and drives the port output registers.

## Interface
- `N_SRC`, default 3: number of source queues (input ports) feeding this output.
- `DW`, default 8: data width; the header word is the first word (`sop`) of every packet.
- `PRI_W`, default 4: priority field width, header bits `[7:4]`; a larger value means higher priority.

- `sys_clk`  in  1  single clock, rising edge.
- `sys_rst`  in  1  asynchronous, active-low reset.
- `src_vld`  in  N_SRC  queue i head word valid (FWFT queue).
- `src_sop`  in  N_SRC  queue i head word is the packet header.
- `src_eop`  in  N_SRC  queue i head word is the last word of its packet.
- `src_data`  in  N_SRC*DW  queue i head word; slice i is `[i*DW +: DW]`.
- `src_rd_en`  out  N_SRC  pop queue i head word (one-hot or zero).
- `out_ready`  in  1  downstream can accept a word this cycle.
- `rd_sop`, `rd_eop`, `rd_vld`  out  1 each  port output strobes.
- `rd_data`  out  DW  port output data.
- `gnt`  out  N_SRC  registered one-hot grant; zero when idle.
- `busy`  out  1  high in XFER.
- `pkt_cnt`  out  16  packets forwarded (eop popped); wraps 0xFFFF to 0.

## Operation
- Request i: `src_vld[i] & src_sop[i]`. Priority i: `src_data[i*DW+4 +: PRI_W]`, i.e. the header `[7:4]`. Header `[3:0]` (dest) is forwarded but not checked.
- FSM, two states:
  - IDLE: `gnt`=0, `src_rd_en`=0. If any request is present, the winner is the maximum priority among requesters. Ties go to the first requester in the order `last+1, last+2, …` mod N_SRC. The next state is XFER with `gnt` set to the winner.
  - XFER, granted source g: `src_rd_en[g] = out_ready & src_vld[g]`, all other bits 0.
  - When a pop occurs with `src_eop[g]`=1: `last` <= g, `pkt_cnt` += 1, and the next state is IDLE.
- Output register: `rd_vld` <= pop. When a pop occurs, `rd_sop/eop/data` <= source g's head. When no pop occurs, `rd_sop`=`rd_eop`=0 and `rd_data` holds its value.
- `src_sop` seen on a non-first word during XFER is forwarded unchanged; it causes no re-arbitration.
- Single-word packet (sop and eop on the same word) is legal: XFER lasts exactly one pop.
- Arbitration happens only in IDLE. A higher-priority request arriving mid-packet waits; there is no preemption.

## Timing
- Reset values: `gnt`=0, `src_rd_en`=0, `rd_*`=0, `busy`=0, `pkt_cnt`=0, state IDLE, `last`=N_SRC-1 (so source 0 wins the first tie).
- `src_rd_en` is combinational from state, `out_ready`, and `src_vld`. All other outputs are registered.
- Request visible in IDLE at cycle t: `gnt`/`busy` high at t+1, first pop at t+1 if `out_ready` and `src_vld`, and `rd_sop`/`rd_vld` at t+2.
- Eop popped at cycle e: IDLE at e+1, next `gnt` at e+2. This gives one mandatory idle cycle between packets.
- `out_ready` low or `src_vld[g]` low in XFER: no pop, `rd_vld`=0, grant held indefinitely.
- Reset asserted mid-packet: all state clears immediately. The partial packet is abandoned with no eop emitted.

## Test plan
- Single packet: source 0, header 0x11 then 0x00..0x41 with eop, `out_ready`=1. Required: `gnt`=001; `rd_sop` with data 0x11 two cycles after the request; 67 contiguous `rd_vld`; `rd_eop` on the last word; `pkt_cnt`=1.
- Priority: sources 1 (0x21) and 2 (0x31) request in the same cycle. Required: source 2 is granted first and its packet completes; one idle cycle follows; then source 1; `pkt_cnt`=2.
- Round-robin: all three sources carry headers with priority 1, each queue holding 2 packets. Required grant order 0,1,2,0,1,2.
- Backpressure: `out_ready` low for 5 cycles mid-packet. Required: `src_rd_en`=0, `rd_vld`=0 for those cycles; `gnt` held; no word lost or duplicated.
- Starved source: `src_vld[g]` drops for 3 cycles mid-packet while another source requests with higher priority. Required: no switch of grant; the packet resumes and completes intact.
- Reset mid-packet: pulse `sys_rst` low at word 10. Required: all outputs 0 asynchronously; after release, source 0 wins a tie with source 1 at equal priority.
